fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter AW, default 3, giving the register address width.
REQ-002 The block SHALL have parameter NSRC, default 2, giving the number of source operands per instruction.
REQ-003 The block SHALL have parameter DEPTH, default 3 (range 2-7), giving the number of in-flight producer stages tracked.
REQ-004 The block SHALL have parameter R0_ZERO, default 0; when 1, address 0 never forwards and never stalls.
REQ-005 The block SHALL define SELW = clog2(DEPTH+1) as a derived width.
REQ-006 The port list SHALL be:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode-stage instruction valid.
- id_src_addr  in  NSRC*AW  source addresses; source n occupies bits [n*AW +: AW].
- id_src_used  in  NSRC  per-source read enable.
- id_dst_addr  in  AW  destination address.
- id_dst_wen  in  1  instruction writes the register file.
- id_is_load  in  1  instruction is a memory load.
- flush  in  1  jump taken; cancel the decode instruction.
- stall  out  1  hold fetch/decode this cycle.
- ex_valid  out  1  execute-stage instruction valid.
- fwd_sel  out  NSRC*SELW  per-source operand select for the execute stage.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-007 The block SHALL hold a DEPTH-entry shift register; each entry is {valid, dst, wen, is_load}; entry[0] is the execute-stage occupant.
REQ-008 On every clock edge, entry[i] SHALL load entry[i-1] for i≥1; the oldest entry is discarded.
REQ-009 entry[0].valid SHALL load id_valid & ~stall & ~flush; dst, wen and is_load SHALL load the id_* inputs.
REQ-010 Entry i SHALL match source n when all hold: entry.valid, entry.wen, id_src_used[n], entry.dst == src_n, and NOT (R0_ZERO==1 and src_n==0).
REQ-011 Candidate code for source n SHALL be i+1, taken from the smallest matching i (youngest producer wins); with no match the code SHALL be 0 (register file).
REQ-012 stall SHALL be combinational: id_valid & ~flush & (some source matches entry[0] with entry[0].is_load).
REQ-013 A load SHALL never forward with code 1; after a one-cycle stall the load sits in entry[1] and forwards with code 2.
REQ-014 fwd_sel SHALL be registered on each edge: the candidate codes when id_valid & ~stall & ~flush, otherwise all zeros.
REQ-015 ex_valid SHALL equal entry[0].valid.
REQ-016 A producer that has left entry[DEPTH-1] SHALL be treated as written to the register file (write-through), so its code is 0.
REQ-017 flush SHALL take priority over stall: when flush=1, stall=0, a bubble enters entry[0], and fwd_sel is cleared.
REQ-018 stall_cnt SHALL increment on each edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-019 No combinational path SHALL exist from any id_* input to fwd_sel or ex_valid.

Reset
REQ-020 While rst_n=0, every entry SHALL be invalid, and fwd_sel=0, ex_valid=0 and stall_cnt=0, regardless of clk.
REQ-021 Because stall depends on entry state, stall SHALL be 0 during reset.
REQ-022 Reset asserted mid-stall SHALL discard all in-flight state; the first instruction after release SHALL see code 0 on every source.
REQ-023 Reset release SHALL be synchronous to clk for the shift register.

Verification
REQ-024 All scenarios SHALL use AW=3, NSRC=2, DEPTH=3, R0_ZERO=0.
REQ-025 Back-to-back ALU dependency: ADD r5 then consumer with src0=r5 -> consumer in execute has fwd_sel[src0]=1, stall never asserted.
REQ-026 Distance-2 and distance-3 producers: r2 written two and three instructions earlier -> codes 2 and 3 respectively; distance 4 -> code 0.
REQ-027 Load-use: LOAD r4 then consumer reading r4 on both sources -> stall=1 for exactly one cycle, one bubble (ex_valid=0), then fwd_sel = {2,2}, stall_cnt=1.
REQ-028 Double write: r1 written at distance 1 and distance 2 -> code 1 (youngest producer wins).
REQ-029 Flush during load-use stall: flush=1 in the stall cycle -> stall=0, bubble inserted, fwd_sel=0, stall_cnt unchanged.
REQ-030 Saturation and reset: force 65536 or more stall cycles -> stall_cnt holds at 16'hFFFF; asserting rst_n=0 mid-run -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding and load-use hazard control for an in-order pipeline.
// Tracks the last DEPTH issued producers, picks the youngest matching producer
// per source operand, and stalls decode for one cycle on a load-use dependency.
module fwd_hazard_ctrl #(
  parameter int unsigned AW      = 3,
  parameter int unsigned NSRC    = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned R0_ZERO = 0,
  localparam int unsigned SELW   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src_addr,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [AW-1:0]        id_dst_addr,
  input  logic                 id_dst_wen,
  input  logic                 id_is_load,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic [15:0]          stall_cnt
);

  localparam int unsigned CNTW = 16;

  // One in-flight producer slot; slot 0 is the execute-stage occupant.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dst;
    logic          wen;
    logic          is_load;
  } entry_t;

  entry_t              pipe_q [DEPTH];
  entry_t              entry_d;
  logic [AW-1:0]       src_addr [NSRC];
  logic [DEPTH-1:0]    hit [NSRC];
  logic [SELW-1:0]     cand [NSRC];
  logic [NSRC-1:0]     load_hit;
  logic                load_use;
  logic                issue;
  logic [NSRC*SELW-1:0] fwd_sel_d;
  logic [CNTW-1:0]     stall_cnt_d;

  // Unpack the flat source address bus.
  always_comb begin
    for (int n = 0; n < int'(NSRC); n++) begin
      src_addr[n] = id_src_addr[n*AW +: AW];
    end
  end

  // Producer/consumer match matrix; address 0 optionally never matches.
  always_comb begin
    for (int n = 0; n < int'(NSRC); n++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        hit[n][i] = pipe_q[i].valid && pipe_q[i].wen && id_src_used[n] &&
                    (pipe_q[i].dst == src_addr[n]) &&
                    !((R0_ZERO != 0) && (src_addr[n] == '0));
      end
    end
  end

  // Youngest matching producer wins; code 0 selects the register file.
  always_comb begin
    for (int n = 0; n < int'(NSRC); n++) begin
      cand[n] = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (hit[n][i]) begin
          cand[n] = SELW'(i + 1);
        end
      end
    end
  end

  // Load result is not available in execute, so a slot-0 load match stalls.
  always_comb begin
    for (int n = 0; n < int'(NSRC); n++) begin
      load_hit[n] = hit[n][0] && pipe_q[0].is_load;
    end
    load_use = |load_hit;
  end

  // Flush overrides stall; stall is idle during reset since slot 0 is invalid.
  assign stall = id_valid && !flush && load_use;
  assign issue = id_valid && !stall && !flush;

  // Next slot-0 contents and next forwarding selects.
  always_comb begin
    entry_d         = '0;
    entry_d.valid   = issue;
    entry_d.dst     = id_dst_addr;
    entry_d.wen     = id_dst_wen;
    entry_d.is_load = id_is_load;
    fwd_sel_d       = '0;
    if (issue) begin
      for (int n = 0; n < int'(NSRC); n++) begin
        fwd_sel_d[n*SELW +: SELW] = cand[n];
      end
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt;
    if (stall && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt + CNTW'(1);
    end
  end

  // Producer shift register; the oldest slot falls off into the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= entry_d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Registered forwarding selects and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel   <= '0;
      stall_cnt <= '0;
    end else begin
      fwd_sel   <= fwd_sel_d;
      stall_cnt <= stall_cnt_d;
    end
  end

  assign ex_valid = pipe_q[0].valid;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, corner sequences and
// random traffic checked against a history-queue reference model.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [2:0]  id_dst_addr;
  logic        id_dst_wen;
  logic        id_is_load;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  fwd_hazard_ctrl #(.AW(3), .NSRC(2), .DEPTH(3), .R0_ZERO(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src_addr (id_src_addr),
    .id_src_used (id_src_used),
    .id_dst_addr (id_dst_addr),
    .id_dst_wen  (id_dst_wen),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .fwd_sel     (fwd_sel),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of issued instructions, index 0 = most recent.
  typedef struct {
    bit       valid;
    bit [2:0] dst;
    bit       wen;
    bit       ld;
  } rec_t;

  rec_t        hist[$];
  logic        m_stall;
  logic        m_exv;
  logic [3:0]  m_sel;
  logic [15:0] m_cnt;
  logic        st_neg;

  typedef struct {
    logic       v;
    logic [2:0] s0;
    logic [2:0] s1;
    logic [1:0] u;
    logic [2:0] d;
    logic       w;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic       e_exv;
    logic [1:0] e_s0;
    logic [1:0] e_s1;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                              input logic [1:0] u, input logic [2:0] d, input logic w,
                              input logic ld, input logic fl, input logic e_stall,
                              input logic e_exv, input logic [1:0] e_s0,
                              input logic [1:0] e_s1, input logic [15:0] e_cnt);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.u = u; r.d = d; r.w = w; r.ld = ld; r.fl = fl;
    r.e_stall = e_stall; r.e_exv = e_exv; r.e_s0 = e_s0; r.e_s1 = e_s1; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Distance to the youngest producer of src, as a forwarding code.
  function automatic logic [1:0] m_code(input logic [2:0] src, input logic used);
    if (!used) return 2'd0;
    for (int k = 0; k < hist.size(); k++) begin
      if (hist[k].valid && hist[k].wen && hist[k].dst == src) return 2'(k + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic m_stall_f();
    logic need;
    need = 1'b0;
    if (hist.size() == 0) return 1'b0;
    if (!(hist[0].valid && hist[0].ld)) return 1'b0;
    if (m_code(id_src_addr[2:0], id_src_used[0]) == 2'd1) need = 1'b1;
    if (m_code(id_src_addr[5:3], id_src_used[1]) == 2'd1) need = 1'b1;
    return id_valid && !flush && need;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_exv = 1'b0;
    m_sel = '0;
    m_cnt = '0;
  endtask

  task automatic model_advance(input logic st);
    rec_t r;
    logic acc;
    acc = id_valid && !st && !flush;
    m_sel = acc ? {m_code(id_src_addr[5:3], id_src_used[1]),
                   m_code(id_src_addr[2:0], id_src_used[0])} : 4'd0;
    r.valid = acc; r.dst = id_dst_addr; r.wen = id_dst_wen; r.ld = id_is_load;
    hist.push_front(r);
    if (hist.size() > 3) void'(hist.pop_back());
    m_exv = acc;
    if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                       input logic [1:0] u, input logic [2:0] d, input logic w,
                       input logic ld, input logic fl);
    id_valid    = v;
    id_src_addr = {s1, s0};
    id_src_used = u;
    id_dst_addr = d;
    id_dst_wen  = w;
    id_is_load  = ld;
    flush       = fl;
  endtask

  // Sample stall at the falling edge, advance across the rising edge.
  task automatic tick();
    @(negedge clk);
    st_neg  = stall;
    m_stall = m_stall_f();
    @(posedge clk);
    model_advance(m_stall);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " stall"},     32'(st_neg),    32'(m_stall));
    chk({tag, " ex_valid"},  32'(ex_valid),  32'(m_exv));
    chk({tag, " fwd_sel"},   32'(fwd_sel),   32'(m_sel));
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  initial begin
    // One row per cycle; expected outputs are those after the rising edge.
    vecs[0]  = mk(1, 0, 0, 2'b00, 5, 1, 0, 0,  0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 5, 3, 2'b11, 6, 1, 0, 0,  0, 1, 1, 0, 0);
    vecs[2]  = mk(1, 0, 0, 2'b00, 2, 1, 0, 0,  0, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 2'b00, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    vecs[4]  = mk(1, 2, 4, 2'b11, 0, 0, 0, 0,  0, 1, 2, 0, 0);
    vecs[5]  = mk(1, 2, 0, 2'b01, 0, 0, 0, 0,  0, 1, 3, 0, 0);
    vecs[6]  = mk(1, 2, 0, 2'b01, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 2'b00, 1, 1, 0, 0,  0, 1, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 2'b00, 1, 1, 0, 0,  0, 1, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 2'b11, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    vecs[10] = mk(1, 0, 0, 2'b00, 4, 1, 1, 0,  0, 1, 0, 0, 0);
    vecs[11] = mk(1, 4, 4, 2'b11, 0, 0, 0, 0,  1, 0, 0, 0, 1);
    vecs[12] = mk(1, 4, 4, 2'b11, 0, 0, 0, 0,  0, 1, 2, 2, 1);
    vecs[13] = mk(1, 0, 0, 2'b00, 3, 1, 1, 0,  0, 1, 0, 0, 1);
    vecs[14] = mk(1, 3, 0, 2'b01, 0, 0, 0, 1,  0, 0, 0, 0, 1);
    vecs[15] = mk(1, 3, 0, 2'b01, 0, 0, 0, 0,  0, 1, 2, 0, 1);
    vecs[16] = mk(0, 3, 0, 2'b01, 0, 0, 0, 0,  0, 0, 0, 0, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    model_reset();
    #3;
    chk("reset stall",     32'(stall),     32'd0);
    chk("reset ex_valid",  32'(ex_valid),  32'd0);
    chk("reset fwd_sel",   32'(fwd_sel),   32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int r = 0; r < 17; r++) begin
      drive(vecs[r].v, vecs[r].s0, vecs[r].s1, vecs[r].u, vecs[r].d,
            vecs[r].w, vecs[r].ld, vecs[r].fl);
      tick();
      chk($sformatf("row%0d stall", r),     32'(st_neg),       32'(vecs[r].e_stall));
      chk($sformatf("row%0d ex_valid", r),  32'(ex_valid),     32'(vecs[r].e_exv));
      chk($sformatf("row%0d sel0", r),      32'(fwd_sel[1:0]), 32'(vecs[r].e_s0));
      chk($sformatf("row%0d sel1", r),      32'(fwd_sel[3:2]), 32'(vecs[r].e_s1));
      chk($sformatf("row%0d stall_cnt", r), 32'(stall_cnt),    32'(vecs[r].e_cnt));
    end

    // Counter saturation: preload near the top, then drive load-use pairs.
    force dut.stall_cnt = 16'hFFFD;
    #1;
    release dut.stall_cnt;
    m_cnt = 16'hFFFD;
    for (int p = 0; p < 4; p++) begin
      drive(1, 0, 0, 2'b00, 4, 1, 1, 0);
      tick();
      cmp_model($sformatf("sat%0d load", p));
      drive(1, 4, 4, 2'b11, 0, 0, 0, 0);
      tick();
      cmp_model($sformatf("sat%0d use", p));
      tick();
      cmp_model($sformatf("sat%0d retry", p));
    end
    chk("saturated stall_cnt", 32'(stall_cnt), 32'h0000FFFF);

    // Asynchronous reset in the middle of a load-use stall.
    drive(1, 0, 0, 2'b00, 2, 1, 0, 0);
    tick();
    drive(1, 2, 0, 2'b01, 4, 1, 1, 0);
    tick();
    chk("load fwd_sel", 32'(fwd_sel), 32'h1);
    drive(1, 4, 4, 2'b11, 0, 0, 0, 0);
    #2;
    chk("pre-reset stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async stall",     32'(stall),     32'd0);
    chk("async ex_valid",  32'(ex_valid),  32'd0);
    chk("async fwd_sel",   32'(fwd_sel),   32'd0);
    chk("async stall_cnt", 32'(stall_cnt), 32'd0);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 4, 4, 2'b11, 0, 0, 0, 0);
    tick();
    chk("post-reset stall",    32'(st_neg),   32'd0);
    chk("post-reset ex_valid", 32'(ex_valid), 32'd1);
    chk("post-reset fwd_sel",  32'(fwd_sel),  32'd0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 1) ? 1'b1 : 1'b0);
      tick();
      cmp_model($sformatf("rand%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
